// File: rtl/add_round_key_stage.sv
// add_round_key_stage: iterative AES-128 round-state register and AddRoundKey.
// Closes the round loop around the external sub_bytes -> shift_rows -> mix_col chain,
// owns the round counter, and accepts one round key per round over valid/ready.
module add_round_key_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plain_in,
  input  logic [127:0] mix_in,
  input  logic [127:0] round_key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] state_out,
  output logic [3:0]   count_out,
  output logic [127:0] data_out,
  output logic         out_valid,
  output logic         busy
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LAST_RD = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } fsm_e;

  fsm_e             fsm_q;
  logic [BLK_W-1:0] state_q;
  logic [BLK_W-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic [BLK_W-1:0] ark_d;
  logic             last_rd_c;

  // Round 0 whitens the plaintext directly; later rounds key the mix_col result.
  always_comb begin
    ark_d     = ((count_q == '0) ? state_q : mix_in) ^ round_key;
    last_rd_c = (count_q == CNT_W'(LAST_RD));
  end

  // Round FSM: one key transfer advances the state by one round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= plain_in;
            count_q <= '0;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (key_valid) begin
            state_q <= ark_d;
            if (last_rd_c) begin
              data_q  <= ark_d;
              valid_q <= 1'b1;
              count_q <= '0;
              fsm_q   <= IDLE;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Outputs are flops or a direct decode of the FSM register.
  always_comb begin
    key_ready = (fsm_q == ROUND);
    busy      = (fsm_q == ROUND);
    state_out = state_q;
    count_out = count_q;
    data_out  = data_q;
    out_valid = valid_q;
  end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage: stub datapath runs plus a full AES-128
// round chain (FIPS-197 Appendix B) modelled around the DUT.
module tb_add_round_key_stage;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] AES_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AES_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] AES_R1    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] AES_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] STUB_LAST = {16{8'h0a}};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plain_in;
  logic [127:0] mix_in;
  logic [127:0] round_key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] state_out;
  logic [3:0]   count_out;
  logic [127:0] data_out;
  logic         out_valid;
  logic         busy;

  logic         aes_mode;
  logic [127:0] rk [0:10];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  add_round_key_stage dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .plain_in  (plain_in),
    .mix_in    (mix_in),
    .round_key (round_key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .state_out (state_out),
    .count_out (count_out),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  function automatic logic [7:0] gb(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[gb(b, i)];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = gb(b, 4*((c+w)%4)+w);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(b, 4*c); a1 = gb(b, 4*c+1); a2 = gb(b, 4*c+2); a3 = gb(b, 4*c+3);
      r[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  // Datapath around the DUT: real AES chain or the all-zero stub with byte-r keys.
  always_comb begin
    mix_in    = '0;
    round_key = {16{4'h0, count_out}};
    if (aes_mode) begin
      mix_in    = shift_rows(sub_bytes(state_out));
      if (count_out != 4'd10) mix_in = mix_columns(mix_in);
      round_key = (count_out <= 4'd10) ? rk[count_out] : '0;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_block(input logic [127:0] p);
    start    = 1'b1;
    plain_in = p;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_ov(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic expand_key();
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = AES_KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; plain_in = '0; key_valid = 1'b0; aes_mode = 1'b0;
    expand_key();
    #2;
    check("rst_state", state_out, '0);
    check("rst_count", 128'(count_out), '0);
    check("rst_data", data_out, '0);
    check("rst_ov", 128'(out_valid), '0);
    check("rst_busy", 128'(busy), '0);
    check("rst_kready", 128'(key_ready), '0);
    tick();
    rst = 1'b0;
    tick();

    // Stub datapath, key_valid held high.
    key_valid = 1'b1;
    begin_block('0);
    check("stub_busy", 128'(busy), 128'(1));
    check("stub_kready", 128'(key_ready), 128'(1));
    check("stub_cnt0", 128'(count_out), '0);
    for (int r = 0; r <= 10; r++) begin
      tick();
      check($sformatf("stub_state_r%0d", r), state_out, {16{8'(r)}});
      check($sformatf("stub_cnt_r%0d", r), 128'(count_out), 128'((r == 10) ? 0 : r + 1));
      check($sformatf("stub_ov_r%0d", r), 128'(out_valid), 128'(r == 10));
    end
    check("stub_data", data_out, STUB_LAST);
    check("stub_busy_ov", 128'(busy), '0);
    tick();
    check("stub_ov_pulse", 128'(out_valid), '0);
    check("stub_data_hold", data_out, STUB_LAST);

    // Key stall of 3 cycles at count 4.
    begin_block('0);
    repeat (4) tick();
    check("stall_cnt_pre", 128'(count_out), 128'(4));
    key_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_cnt", 128'(count_out), 128'(4));
      check("stall_state", state_out, {16{8'h03}});
      check("stall_kready", 128'(key_ready), 128'(1));
      check("stall_ov", 128'(out_valid), '0);
    end
    key_valid = 1'b1;
    wait_ov(30, n);
    check("stall_latency", 128'(4 + 3 + n), 128'(14));
    check("stall_data", data_out, STUB_LAST);
    tick();

    // start while busy must be ignored.
    begin_block('0);
    repeat (6) tick();
    check("sbusy_cnt6", 128'(count_out), 128'(6));
    begin_block({128{1'b1}});
    check("sbusy_cnt7", 128'(count_out), 128'(7));
    check("sbusy_state", state_out, {16{8'h06}});
    n = 0;
    while (!out_valid && n < 30) begin
      check("sbusy_busy", 128'(busy), 128'(1));
      tick();
      n++;
    end
    check("sbusy_latency", 128'(n), 128'(4));
    check("sbusy_data", data_out, STUB_LAST);
    check("sbusy_busy_ov", 128'(busy), '0);
    tick();

    // FIPS-197 Appendix B with back-to-back blocks.
    aes_mode = 1'b1;
    begin_block(AES_PT);
    check("aes_state_e0", state_out, AES_PT);
    tick();
    check("aes_state_e1", state_out, AES_R1);
    wait_ov(30, n);
    check("aes_latency", 128'(n + 1), 128'(11));
    check("aes_data", data_out, AES_CT);
    begin_block(AES_PT);
    check("b2b_ov_pulse", 128'(out_valid), '0);
    check("b2b_busy", 128'(busy), 128'(1));
    check("b2b_cnt", 128'(count_out), '0);
    check("b2b_state", state_out, AES_PT);
    wait_ov(30, n);
    check("b2b_spacing", 128'(n + 1), 128'(12));
    check("b2b_data", data_out, AES_CT);
    tick();

    // Reset mid-round at count 5 aborts the block and clears data_out.
    aes_mode = 1'b0;
    begin_block('0);
    repeat (5) tick();
    check("abort_cnt5", 128'(count_out), 128'(5));
    #2;
    rst = 1'b1;
    #1;
    check("abort_state", state_out, '0);
    check("abort_count", 128'(count_out), '0);
    check("abort_data", data_out, '0);
    check("abort_ov", 128'(out_valid), '0);
    check("abort_busy", 128'(busy), '0);
    check("abort_kready", 128'(key_ready), '0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("abort_no_ov", 128'(n), '0);
    check("abort_idle", 128'(busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_round_key_stage.md
# add_round_key_stage

Iterative AES-128 round-state holder and AddRoundKey stage. Sits directly downstream of mix_col and closes the round loop: it XORs the mix_col result with the current round key, registers it as the new round state, and feeds that state back into the sub_bytes → shift_rows → mix_col chain. It owns the round counter that drives mix_col's count_out input (mix_col bypasses mixing when count_out = 10). Round keys arrive from the key schedule through a valid/ready handshake.

## Interface
- No parameters; widths fixed by AES-128. Block width 128, round index 4 bits, last round NR = 10.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin encrypting plain_in; sampled only in IDLE.
- plain_in  in  128  plaintext block, captured on the accepted start edge.
- mix_in  in  128  combinational data_out of mix_col, computed from state_out.
- round_key  in  128  round key for round count_out.
- key_valid  in  1  round_key is valid.
- key_ready  out  1  combinational; high exactly when FSM = ROUND.
- state_out  out  128  current round-state register; drives sub_bytes.
- count_out  out  4  current round index 0..10; drives mix_col and the key schedule.
- data_out  out  128  ciphertext register; holds its value until the next completion.
- out_valid  out  1  one-cycle pulse when data_out is updated.
- busy  out  1  high whenever FSM ≠ IDLE.

## Operation
- FSM states: IDLE, ROUND.
- IDLE:
  - busy = 0, key_ready = 0.
  - On start: state ← plain_in, count ← 0, go to ROUND.
- ROUND, key accepted (key_valid = 1 on the edge):
  - If count = 0: next = state_out ^ round_key. Initial AddRoundKey; mix_in is ignored.
  - If count = 1..10: next = mix_in ^ round_key.
  - If count < 10: state ← next, count ← count + 1, stay in ROUND.
  - If count = 10: state ← next, data_out ← next, out_valid ← 1 for one cycle, count ← 0, go to IDLE.
- ROUND with key_valid = 0: stall. State, count and all outputs hold.
- Handshake: a key transfer occurs on every edge where key_valid and key_ready are both high. There is no skid buffer, and round_key must be stable while key_valid is high.
- start is ignored while busy; it is not queued.
- Arithmetic: count is 4-bit and never exceeds 10. No wrap is possible because the FSM returns to IDLE at 10.
- Invariant: count_out = 0 whenever FSM = IDLE.

## Timing
- Reset values (asynchronous, immediate): FSM = IDLE, state_out = 0, count_out = 0, data_out = 0, out_valid = 0, busy = 0, key_ready = 0.
- Reset asserted mid-operation: the block aborts with no out_valid, and data_out is cleared to 0.
- Latency with key_valid held high: let edge E0 be the edge that accepts start.
  - Keys for rounds 0..10 are accepted on edges E1..E11.
  - out_valid is high for the cycle following E11, i.e. 11 cycles after E0.
  - Each cycle key_valid is low adds one cycle of latency.
- Back-to-back blocks: start may be asserted in the same cycle out_valid is high, since the FSM is already IDLE. The next block begins on that edge, so throughput is one block per 12 cycles.
- count_out and state_out are registered. The mix_in path (state_out → sub_bytes → shift_rows → mix_col → mix_in) is single-cycle combinational and must close timing within one clk period.

## Test plan
- Reset: assert rst mid-round at count_out = 5 → all outputs read 0 immediately; busy = 0; no out_valid pulse ever appears for the aborted block.
- FIPS-197 Appendix B:
  - Stimulus: real sub_bytes/shift_rows/mix_col chain on mix_in, key schedule from key 2b7e151628aed2a6abf7158809cf4f3c, plain_in 3243f6a8885a308d313198a2e0370734.
  - After E1: state_out = 193de3bea0f4e22b9ac68d2ae9f84808.
  - After E11: data_out = 3925841d02dc09fbdc118597196a0b32, out_valid high for exactly one cycle.
- Stub datapath:
  - Stimulus: mix_in held at 0; round key r = 16 repetitions of byte r; plain_in = 0.
  - After each edge: state_out = 16 repetitions of byte (r), and count_out steps 0,1,…,10,0.
  - Final data_out = 0a0a…0a (all 16 bytes 0x0a).
- Key stall: drop key_valid for 3 cycles at count_out = 4 → state_out and count_out hold, key_ready stays high, out_valid arrives 3 cycles later than the no-stall case, and data_out is unchanged versus the no-stall run.
- start while busy: pulse start with a different plain_in at count_out = 6 → ignored; the original result is produced; busy stays high until the out_valid cycle.
- Back-to-back: assert start in the out_valid cycle → second block is accepted on that edge; the second out_valid pulse appears exactly 12 cycles after the first.
